adc_sample_scheduler: RTL

Supervises and post-processes the ADS1115 I2C front end. Drives the controller's active-low reset, detects each completed conversion from the toggling channel flag, and demultiplexes the sample stream into per-channel registers with single-cycle valid strobes. Produces per-channel block averages and restarts a stalled controller through a watchdog. Sits between the ADC controller and the train-speed/throttle logic.

---
 rtl/adc_sched_pkg.sv | 23 ++
 rtl/adc_sample_scheduler_block_avg.sv | 63 ++++++
 rtl/adc_sample_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/adc_sched_pkg.sv
// adc_sched_pkg: shared types and defaults for the ADS1115 sample scheduler.
//   state_t    - supervisor FSM states
//   DEF_*      - default parameter values
//   acc_width  - width of the per-channel signed block accumulator
package adc_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam int unsigned SAMPLE_W         = 16;
    localparam int unsigned DEF_AVG_LOG2     = 2;
    localparam int unsigned DEF_TIMEOUT_CYC  = 20000;
    localparam int unsigned DEF_RST_HOLD_CYC = 4;

    // Accumulator wide enough to sum 2^avg_log2 full-scale signed samples.
    function automatic int unsigned acc_width(input int unsigned avg_log2);
        return SAMPLE_W + avg_log2;
    endfunction

endpackage

// File: rtl/adc_sample_scheduler_block_avg.sv
// adc_block_avg: per-channel block averager.
//   clk, rst   - clock, async active-high reset
//   sample     - signed 16-bit sample, accepted when strobe = 1
//   strobe     - new sample for this channel
//   clear      - discard the partial block (priority over strobe)
//   avg        - signed block average, sum >>> AVG_LOG2 (rounds toward -inf)
//   avg_valid  - one-cycle strobe when avg updates
module adc_block_avg
    import adc_sched_pkg::*;
#(
    parameter int unsigned AVG_LOG2 = DEF_AVG_LOG2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] sample,
    input  logic        strobe,
    input  logic        clear,
    output logic [15:0] avg,
    output logic        avg_valid
);

    localparam int unsigned ACC_W = acc_width(AVG_LOG2);
    localparam int unsigned CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] sum_c;
    logic signed [ACC_W-1:0] shifted_c;
    logic signed [15:0]      sample_s;
    logic [CNT_W-1:0]        cnt;

    // Sign-extend the sample into the accumulator width and form the block result.
    assign sample_s  = sample;
    assign sum_c     = acc + ACC_W'(sample_s);
    assign shifted_c = sum_c >>> AVG_LOG2;

    // Accumulate, emit the average on the last sample of the block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            avg       <= '0;
            avg_valid <= 1'b0;
        end else begin
            avg_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                cnt <= '0;
            end else if (strobe) begin
                if (cnt == CNT_LAST) begin
                    avg       <= shifted_c[15:0];
                    avg_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= sum_c;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: supervisor and post-processor for the ADS1115 I2C controller.
//   i_clk_100k, i_rst       - clock (rising edge), async active-high reset
//   i_enable                - run request; low holds the controller in reset
//   i_adc_data, i_adc_chn   - controller result and toggling channel flag
//   o_adc_rst_n             - controller reset, registered
//   o_ch0/1_data, o_valid, o_valid_chn - demuxed raw samples and strobe
//   o_ch0/1_avg, o_avg_valid           - per-channel block averages and strobes
//   o_fault, o_restart_cnt  - sticky watchdog fault, saturating restart count
module adc_sample_scheduler
    import adc_sched_pkg::*;
#(
    parameter int unsigned AVG_LOG2     = DEF_AVG_LOG2,
    parameter int unsigned TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int unsigned RST_HOLD_CYC = DEF_RST_HOLD_CYC
) (
    input  logic        i_clk_100k,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic [15:0] i_adc_data,
    input  logic        i_adc_chn,
    output logic        o_adc_rst_n,
    output logic [15:0] o_ch0_data,
    output logic [15:0] o_ch1_data,
    output logic        o_valid,
    output logic        o_valid_chn,
    output logic [15:0] o_ch0_avg,
    output logic [15:0] o_ch1_avg,
    output logic [1:0]  o_avg_valid,
    output logic        o_fault,
    output logic [7:0]  o_restart_cnt
);

    localparam int unsigned WD_W   = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned HOLD_W = $clog2(RST_HOLD_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);

    state_t            state;
    state_t            state_nxt;
    logic              chn_d;
    logic [WD_W-1:0]   wd_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              tog_c;
    logic              wd_expire_c;
    logic              restart_c;
    logic              acc_clear_c;

    // Next state; toggles only count in S_RUN so the controller's forced flag is ignored.
    always_comb begin
        state_nxt   = state;
        tog_c       = 1'b0;
        wd_expire_c = 1'b0;
        restart_c   = 1'b0;
        acc_clear_c = 1'b1;
        case (state)
            S_IDLE: begin
                if (i_enable) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (!i_enable)                  state_nxt = S_IDLE;
                else if (hold_cnt == HOLD_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                tog_c       = (i_adc_chn != chn_d);
                // A sample arriving in the expiry cycle keeps the controller alive.
                wd_expire_c = !tog_c && (wd_cnt == WD_LAST);
                restart_c   = i_enable && wd_expire_c;
                acc_clear_c = !i_enable || wd_expire_c;
                if (!i_enable)       state_nxt = S_IDLE;
                else if (wd_expire_c) state_nxt = S_HOLD;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, counters and the registered controller reset.
    always_ff @(posedge i_clk_100k or posedge i_rst) begin
        if (i_rst) begin
            state       <= S_IDLE;
            chn_d       <= 1'b1;
            hold_cnt    <= '0;
            wd_cnt      <= '0;
            o_adc_rst_n <= 1'b0;
        end else begin
            state       <= state_nxt;
            chn_d       <= i_adc_chn;
            o_adc_rst_n <= (state_nxt == S_RUN);
            hold_cnt    <= (state == S_HOLD) ? hold_cnt + HOLD_W'(1) : '0;
            // Zero on entry to S_RUN, on every qualified sample, and outside S_RUN.
            if (state == S_RUN && state_nxt == S_RUN && !tog_c)
                wd_cnt <= wd_cnt + WD_W'(1);
            else
                wd_cnt <= '0;
        end
    end

    // Raw sample demux and watchdog bookkeeping.
    always_ff @(posedge i_clk_100k or posedge i_rst) begin
        if (i_rst) begin
            o_ch0_data    <= '0;
            o_ch1_data    <= '0;
            o_valid       <= 1'b0;
            o_valid_chn   <= 1'b0;
            o_fault       <= 1'b0;
            o_restart_cnt <= '0;
        end else begin
            o_valid <= tog_c;
            if (tog_c) begin
                o_valid_chn <= i_adc_chn;
                if (i_adc_chn) o_ch1_data <= i_adc_data;
                else           o_ch0_data <= i_adc_data;
            end
            if (restart_c) begin
                o_fault <= 1'b1;
                if (o_restart_cnt != 8'hFF) o_restart_cnt <= o_restart_cnt + 8'd1;
            end
        end
    end

    adc_block_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_ch0 (
        .clk       (i_clk_100k),
        .rst       (i_rst),
        .sample    (i_adc_data),
        .strobe    (tog_c && !i_adc_chn),
        .clear     (acc_clear_c),
        .avg       (o_ch0_avg),
        .avg_valid (o_avg_valid[0])
    );

    adc_block_avg #(.AVG_LOG2(AVG_LOG2)) u_avg_ch1 (
        .clk       (i_clk_100k),
        .rst       (i_rst),
        .sample    (i_adc_data),
        .strobe    (tog_c && i_adc_chn),
        .clear     (acc_clear_c),
        .avg       (o_ch1_avg),
        .avg_valid (o_avg_valid[1])
    );

endmodule
